// File: rtl/pc_addr_stack.sv
// Program counter plus an 8-level push-down return-address stack for the 8008 core.
// Entry[sp] is the live PC. The block also registers the address byte that the bus puts out in T1/T2.
module pc_addr_stack #(
  parameter  int WIDTH      = 8,
  parameter  int ADDR_WIDTH = 14,
  parameter  int DEPTH      = 8,
  localparam int SP_W       = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [2:0]            op,
  input  logic                  cond_ok,
  input  logic [2:0]            rst_vec,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  tgt_lo_we,
  input  logic                  tgt_hi_we,
  input  logic [1:0]            cycle,
  input  logic [1:0]            addr_sel,
  output logic [WIDTH-1:0]      addr_out,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [SP_W-1:0]       sp,
  output logic                  stk_wrap
);

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_INC  = 3'b001,
    OP_JMP  = 3'b010,
    OP_CALL = 3'b011,
    OP_RET  = 3'b100,
    OP_RST  = 3'b101
  } op_e;

  localparam int HI_W = ADDR_WIDTH - WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);
  localparam logic [SP_W-1:0]       SP_ONE = SP_W'(1);
  localparam logic [SP_W-1:0]       SP_MAX = SP_W'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0] r_stack [DEPTH];
  logic [SP_W-1:0]       r_sp;
  logic [ADDR_WIDTH-1:0] r_tgt;
  logic [WIDTH-1:0]      r_addr;
  logic                  r_wrap;

  logic [ADDR_WIDTH-1:0] w_pc;
  logic [ADDR_WIDTH-1:0] w_rst_tgt;
  logic [SP_W-1:0]       w_sp_next;
  logic                  w_wr_en;
  logic [SP_W-1:0]       w_wr_idx;
  logic [ADDR_WIDTH-1:0] w_wr_val;
  logic                  w_wrap;
  logic [WIDTH-1:0]      w_hi_byte;

  assign w_pc      = r_stack[r_sp];
  assign w_rst_tgt = {{(ADDR_WIDTH-6){1'b0}}, rst_vec, 3'b000};

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_sp_next = r_sp;
    w_wr_en   = 1'b0;
    w_wr_idx  = r_sp;
    w_wr_val  = w_pc;
    w_wrap    = 1'b0;
    if (en) begin
      case (op_e'(op))
        OP_INC: begin
          w_wr_en  = 1'b1;
          w_wr_val = w_pc + PC_ONE;
        end
        OP_JMP: begin
          if (cond_ok) begin
            w_wr_en  = 1'b1;
            w_wr_val = r_tgt;
          end
        end
        OP_CALL, OP_RST: begin
          if (cond_ok || op_e'(op) == OP_RST) begin
            w_sp_next = r_sp + SP_ONE;
            w_wr_en   = 1'b1;
            w_wr_idx  = r_sp + SP_ONE;
            w_wr_val  = (op_e'(op) == OP_RST) ? w_rst_tgt : r_tgt;
            w_wrap    = (r_sp == SP_MAX);
          end
        end
        OP_RET: begin
          if (cond_ok) begin
            w_sp_next = r_sp - SP_ONE;
            w_wrap    = (r_sp == '0);
          end
        end
        default: ;
      endcase
    end
  end

  // The high byte is built field by field, so the zero pad can shrink to nothing with the default widths.
  always_comb begin
    w_hi_byte                 = '0;
    w_hi_byte[HI_W-1:0]       = w_pc[ADDR_WIDTH-1:WIDTH];
    w_hi_byte[WIDTH-1 -: 2]   = cycle;
  end

  // NOTE: the stack array is cleared on reset because a wrapped RET exposes entries that were never written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_stack[i] <= '0;
      r_sp   <= '0;
      r_tgt  <= '0;
      r_addr <= '0;
      r_wrap <= 1'b0;
    end else begin
      // NOTE: non-blocking updates ensure the target write and the op in the same cycle both see the old tgt.
      if (w_wr_en) r_stack[w_wr_idx] <= w_wr_val;
      r_sp   <= w_sp_next;
      r_wrap <= w_wrap;
      if (en) begin
        if (tgt_lo_we) r_tgt[WIDTH-1:0]          <= data_in;
        if (tgt_hi_we) r_tgt[ADDR_WIDTH-1:WIDTH] <= data_in[HI_W-1:0];
        case (addr_sel)
          2'b01:   r_addr <= w_pc[WIDTH-1:0];
          2'b10:   r_addr <= w_hi_byte;
          default: ;
        endcase
      end
    end
  end

  assign pc       = w_pc;
  assign sp       = r_sp;
  assign addr_out = r_addr;
  assign stk_wrap = r_wrap;

endmodule

// File: tb/tb_pc_addr_stack.sv
// Self-checking bench for pc_addr_stack. A behavioural model pushes the expected post-edge
// outputs into a queue, and each queue entry is compared with the DUT one cycle later.
module tb_pc_addr_stack;

  logic        clk = 1'b0;
  logic        rst_n, en, cond_ok, tgt_lo_we, tgt_hi_we;
  logic [2:0]  op, rst_vec;
  logic [7:0]  data_in;
  logic [1:0]  cycle, addr_sel;
  logic [7:0]  addr_out;
  logic [13:0] pc;
  logic [2:0]  sp;
  logic        stk_wrap;

  pc_addr_stack dut (
    .clk(clk), .rst_n(rst_n), .en(en), .op(op), .cond_ok(cond_ok), .rst_vec(rst_vec),
    .data_in(data_in), .tgt_lo_we(tgt_lo_we), .tgt_hi_we(tgt_hi_we), .cycle(cycle),
    .addr_sel(addr_sel), .addr_out(addr_out), .pc(pc), .sp(sp), .stk_wrap(stk_wrap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [13:0] pc;
    logic [2:0]  sp;
    logic [7:0]  addr;
    logic        wrap;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  logic [13:0] m_stk [8];
  logic [2:0]  m_sp;
  logic [13:0] m_tgt;
  logic [7:0]  m_addr;
  logic        m_wrap;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Expected next state, written directly from the op definitions.
  task automatic model(input logic rn, input logic e, input logic [2:0] o, input logic c,
                       input logic [2:0] v, input logic [7:0] d, input logic lo, input logic hi,
                       input logic [1:0] cy, input logic [1:0] sel);
    logic [13:0] cur;
    if (!rn) begin
      for (int i = 0; i < 8; i++) m_stk[i] = 14'h0;
      m_sp = 3'd0; m_tgt = 14'h0; m_addr = 8'h00; m_wrap = 1'b0;
    end else if (!e) begin
      m_wrap = 1'b0;
    end else begin
      cur = m_stk[m_sp];
      if (sel == 2'b01) m_addr = cur[7:0];
      else if (sel == 2'b10) m_addr = {cy, cur[13:8]};
      m_wrap = 1'b0;
      case (o)
        3'b001: m_stk[m_sp] = cur + 14'd1;
        3'b010: if (c) m_stk[m_sp] = m_tgt;
        3'b011: if (c) begin
          m_wrap = (m_sp == 3'd7);
          m_sp = m_sp + 3'd1;
          m_stk[m_sp] = m_tgt;
        end
        3'b100: if (c) begin
          m_wrap = (m_sp == 3'd0);
          m_sp = m_sp - 3'd1;
        end
        3'b101: begin
          m_wrap = (m_sp == 3'd7);
          m_sp = m_sp + 3'd1;
          m_stk[m_sp] = {8'h00, v, 3'b000};
        end
        default: ;
      endcase
      if (lo) m_tgt[7:0] = d;
      if (hi) m_tgt[13:8] = d[5:0];
    end
  endtask

  task automatic cyc(input logic [2:0] o, input logic c = 1'b1, input logic rn = 1'b1,
                     input logic e = 1'b1, input logic [7:0] d = 8'h00, input logic lo = 1'b0,
                     input logic hi = 1'b0, input logic [2:0] v = 3'd0,
                     input logic [1:0] cy = 2'b00, input logic [1:0] sel = 2'b00);
    exp_t x;
    @(negedge clk);
    rst_n = rn; en = e; op = o; cond_ok = c; data_in = d; tgt_lo_we = lo; tgt_hi_we = hi;
    rst_vec = v; cycle = cy; addr_sel = sel;
    model(rn, e, o, c, v, d, lo, hi, cy, sel);
    x.pc = m_stk[m_sp]; x.sp = m_sp; x.addr = m_addr; x.wrap = m_wrap;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    check("pc", 32'(pc), 32'(x.pc));
    check("sp", 32'(sp), 32'(x.sp));
    check("addr_out", 32'(addr_out), 32'(x.addr));
    check("stk_wrap", 32'(stk_wrap), 32'(x.wrap));
  endtask

  task automatic load_tgt(input logic [13:0] t);
    cyc(3'b000, 1'b1, 1'b1, 1'b1, t[7:0], 1'b1, 1'b0);
    cyc(3'b000, 1'b1, 1'b1, 1'b1, {2'b00, t[13:8]}, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; op = 3'b000; cond_ok = 1'b0; rst_vec = 3'd0; data_in = 8'h00;
    tgt_lo_we = 1'b0; tgt_hi_we = 1'b0; cycle = 2'b00; addr_sel = 2'b00;

    // 1: reset then five increments
    cyc(3'b011, 1'b1, 1'b0);
    cyc(3'b011, 1'b1, 1'b0);
    check("rst_pc", 32'(pc), 32'h0);
    for (int i = 0; i < 5; i++) cyc(3'b001);
    check("t1_pc", 32'(pc), 32'h0005);
    check("t1_sp", 32'(sp), 32'h0);

    // 2: jump to the top of the address space, then roll over
    load_tgt(14'h3FFF);
    cyc(3'b010);
    check("t2_jmp", 32'(pc), 32'h3FFF);
    cyc(3'b001);
    check("t2_roll", 32'(pc), 32'h0000);

    // 3: call / return / a jump whose condition fails
    for (int i = 0; i < 16; i++) cyc(3'b001);
    load_tgt(14'h1234);
    cyc(3'b011);
    check("t3_call_pc", 32'(pc), 32'h1234);
    check("t3_call_sp", 32'(sp), 32'h1);
    cyc(3'b100);
    check("t3_ret_pc", 32'(pc), 32'h0010);
    cyc(3'b010, 1'b0);
    check("t3_jmp_nc", 32'(pc), 32'h0010);

    // 4: push the stack until it wraps, then pop back through zero
    for (int i = 0; i < 8; i++) cyc(3'b011);
    check("t4_sp", 32'(sp), 32'h0);
    check("t4_wrap", 32'(stk_wrap), 32'h1);
    check("t4_e0", 32'(pc), 32'h1234);
    cyc(3'b000);
    check("t4_wrap_drop", 32'(stk_wrap), 32'h0);
    cyc(3'b100);
    check("t4_ret_sp", 32'(sp), 32'h7);
    check("t4_ret_wrap", 32'(stk_wrap), 32'h1);
    cyc(3'b000);

    // 5: restart vector leaves the staged target alone
    cyc(3'b000, 1'b1, 1'b0);
    load_tgt(14'h0100);
    cyc(3'b011);
    cyc(3'b011);
    load_tgt(14'h0777);
    cyc(3'b101, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 3'd5);
    check("t5_rst_pc", 32'(pc), 32'h0028);
    check("t5_rst_sp", 32'(sp), 32'h3);
    cyc(3'b100);
    check("t5_ret_pc", 32'(pc), 32'h0100);
    cyc(3'b010);
    check("t5_tgt", 32'(pc), 32'h0777);

    // 6: address bytes, enable freeze, reset during a call
    load_tgt(14'h2A5C);
    cyc(3'b010);
    cyc(3'b000, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 2'b10, 2'b01);
    check("t6_lo", 32'(addr_out), 32'h5C);
    cyc(3'b000, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 2'b10, 2'b10);
    check("t6_hi", 32'(addr_out), 32'hAA);
    cyc(3'b001, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 2'b00, 2'b01);
    check("t6_en_pc", 32'(pc), 32'h2A5C);
    check("t6_en_addr", 32'(addr_out), 32'hAA);
    cyc(3'b011, 1'b1, 1'b0);
    check("t6_rst_pc", 32'(pc), 32'h0);
    check("t6_rst_sp", 32'(sp), 32'h0);

    // Random mix, including reserved opcodes and simultaneous target writes
    for (int i = 0; i < 300; i++) begin
      cyc(3'($urandom_range(0, 7)), 1'($urandom), 1'b1, ($urandom_range(0, 7) != 0),
          8'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 2'($urandom), 2'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_addr_stack.md
Name: pc_addr_stack

Overview:
- Program-counter and 8-level push-down address stack for the 8008 core. Entry[sp] is the live PC.
- Executes sequencing ops issued by the decoder/controller: increment, jump, call, return, restart.
- Stages 14-bit jump/call targets byte by byte from the internal data bus.
- Drives the registered low/high address byte that the bus interface places on D_out during T1/T2.

Parameters:
WIDTH, 8, data bus / address-byte width
ADDR_WIDTH, 14, PC and stack-entry width; requires ADDR_WIDTH-WIDTH+2 <= WIDTH
DEPTH, 8, stack entries including the live PC; power of two; SP_W = $clog2(DEPTH)

Ports:
clk  in  1  single clock, all state updates on posedge
rst_n  in  1  synchronous, active-low reset
en  in  1  advance enable; en=0 freezes all state and addr_out
op  in  3  000 NOP, 001 INC, 010 JMP, 011 CALL, 100 RET, 101 RST, 110/111 reserved (treated as NOP)
cond_ok  in  1  condition result for JMP/CALL/RET
rst_vec  in  3  restart vector for RST
data_in  in  WIDTH  internal data bus, source for target bytes
tgt_lo_we  in  1  load tgt[7:0] from data_in
tgt_hi_we  in  1  load tgt[13:8] from data_in[5:0]
cycle  in  2  cycle-type code inserted into high address byte
addr_sel  in  2  00 hold, 01 capture low byte, 10 capture high byte, 11 hold
addr_out  out  WIDTH  registered address byte for bus interface
pc  out  ADDR_WIDTH  current PC = entry[sp], combinational from state
sp  out  SP_W  stack pointer
stk_wrap  out  1  one-cycle pulse on stack pointer wrap

Behaviour:
- Reset (rst_n=0 at posedge, any op in flight is discarded): all entries=0, sp=0, tgt=0, addr_out=0, stk_wrap=0. Reset has priority over en.
- en=0: no state change. stk_wrap=0 on the next cycle.
- All updates below take effect at the posedge with en=1. There is one op per cycle.
- INC: entry[sp] <= entry[sp]+1 mod 2^ADDR_WIDTH, so 0x3FFF -> 0x0000.
- JMP with cond_ok=1: entry[sp] <= tgt. With cond_ok=0: NOP, and the PC is not incremented.
- CALL with cond_ok=1:
  - sp <= sp+1 mod DEPTH; entry[sp+1] <= tgt.
  - entry[old sp] is kept as the return address. The controller has already advanced the PC past the instruction.
  - With cond_ok=0: NOP.
- RET with cond_ok=1: sp <= sp-1 mod DEPTH; entries are untouched. With cond_ok=0: NOP.
- RST: unconditional, ignores cond_ok. Behaves as CALL with target {zeros, rst_vec, 3'b000}; tgt is not modified.
- Stack wrap:
  - CALL/RST at sp=DEPTH-1 -> sp=0; entry[0] is overwritten (oldest address lost).
  - RET at sp=0 -> sp=DEPTH-1.
  - In both cases stk_wrap=1 for exactly the following cycle. No other error handling.
- Target latch:
  - tgt_lo_we and tgt_hi_we may both be asserted and are independent of op.
  - A JMP/CALL issued in the same cycle as a target write uses the pre-write tgt. The new tgt is visible next cycle.
- addr_out:
  - 1-cycle latency; samples the pre-op PC of the same cycle.
  - sel=01: pc[7:0].
  - sel=10: {cycle, {(WIDTH-2-(ADDR_WIDTH-WIDTH)){1'b0}}, pc[ADDR_WIDTH-1:WIDTH]}; with defaults {cycle, pc[13:8]}.
  - sel=00/11: hold.
- sp and pc outputs reflect post-update state from the cycle after the op.

Test Plan:
1. rst_n=0 for 2 clk, then en=1, 5x INC -> pc=0x0005, sp=0, addr_out=0x00, stk_wrap=0.
2. data_in=0xFF with tgt_lo_we, data_in=0x3F with tgt_hi_we, JMP cond_ok=1 -> pc=0x3FFF; INC -> pc=0x0000.
3. pc=0x0010, tgt=0x1234, CALL cond_ok=1 -> pc=0x1234, sp=1; RET cond_ok=1 -> pc=0x0010, sp=0; JMP cond_ok=0 -> pc stays 0x0010.
4. 8 consecutive CALLs from sp=0 -> 8th leaves sp=0, stk_wrap high exactly one cycle, entry[0]=tgt; RET at sp=0 -> sp=7, stk_wrap pulse.
5. RST rst_vec=5 from pc=0x0100, sp=2 -> pc=0x0028, sp=3, tgt unchanged; RET -> pc=0x0100.
6. Address bytes and control priority:
   - pc=0x2A5C, cycle=2'b10, sel=01 -> next cycle addr_out=0x5C.
   - sel=10 -> addr_out=0xAA.
   - en=0 with op=INC -> pc, addr_out unchanged.
   - rst_n=0 during a CALL -> pc=0, sp=0.
